// File: rtl/uart_msg_handler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msg_defs (package)
//  Description : Shared codes, frame lengths, parser/serializer enums and
//                byte-select helpers for the miner-side UART message engine.
//  Revision    : 1.0  initial release
// ============================================================================
package msg_defs;

  // Single-byte messages.
  localparam logic [7:0] MSG_PING = 8'h00;
  localparam logic [7:0] MSG_PONG = 8'h01;
  localparam logic [7:0] MSG_ACK  = 8'h01;

  // Frame type codes (byte 3 of a frame header).
  localparam logic [7:0] TYPE_GET_INFO = 8'd0;
  localparam logic [7:0] TYPE_INVALID  = 8'd1;
  localparam logic [7:0] TYPE_PUSH_JOB = 8'd2;
  localparam logic [7:0] TYPE_NONCE    = 8'd3;

  // Frame lengths, header included.
  localparam logic [7:0] LEN_GET_INFO = 8'd8;
  localparam logic [7:0] LEN_PUSH_JOB = 8'd60;
  localparam logic [7:0] MIN_LEN      = 8'd8;
  localparam logic [7:0] MAX_LEN      = 8'd60;
  localparam logic [7:0] LEN_INFO     = 8'd16;
  localparam logic [7:0] LEN_SHORT    = 8'd8;   // INVALID and NONCE replies

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_HDR     = 2'd1,
    PS_PAYLOAD = 2'd2
  } parse_state_e;

  // PONG and ACK are both the single byte 0x01, so they share TXM_ONE.
  typedef enum logic [1:0] {
    TXM_ONE     = 2'd0,
    TXM_INFO    = 2'd1,
    TXM_INVALID = 2'd2,
    TXM_NONCE   = 2'd3
  } tx_msg_e;

  // Index of the last byte of each outgoing message.
  function automatic logic [3:0] msg_last_idx(input tx_msg_e m);
    case (m)
      TXM_ONE:  msg_last_idx = 4'd0;
      TXM_INFO: msg_last_idx = 4'd15;
      default:  msg_last_idx = 4'd7;
    endcase
  endfunction

  // Byte i of a 32-bit word sent MSB-first.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    word_byte = w[31:24];
      2'd1:    word_byte = w[23:16];
      2'd2:    word_byte = w[15:8];
      default: word_byte = w[7:0];
    endcase
  endfunction

  // Byte i of a 4-byte reply header: length, 0, 0, type.
  function automatic logic [7:0] hdr_byte(input logic [7:0] len, input logic [7:0] typ,
                                          input logic [1:0] i);
    case (i)
      2'd0:    hdr_byte = len;
      2'd3:    hdr_byte = typ;
      default: hdr_byte = 8'h00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : msg_tx_serializer
//  Description : Walks the bytes of one outgoing message and presents them on
//                a valid/ready byte interface. A message is latched on start
//                (message select and nonce); done pulses combinationally in
//                the cycle the last byte is consumed.
//  Ports       : CLK, RST        clock, synchronous active-high reset
//                start, msg_sel  begin sending message msg_sel (ignored if busy)
//                nonce           nonce for the NONCE message
//                done            last byte consumed this cycle
//                tx_data/valid   byte stream out; tx_valid doubles as busy
//                tx_ready        byte consumed when tx_valid && tx_ready
//  Revision    : 1.0  initial release
// ============================================================================
module msg_tx_serializer
  import msg_defs::*;
#(
  parameter logic [31:0] INFO_ID0 = 32'hDEADBEEF,
  parameter logic [31:0] INFO_ID1 = 32'h13370D13
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  msg_sel,
  input  logic [31:0] nonce,
  output logic        done,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic        busy_q, busy_d;
  logic [3:0]  idx_q, idx_d;
  tx_msg_e     sel_q, sel_d;
  logic [31:0] nonce_q, nonce_d;

  assign tx_valid = busy_q;
  assign done     = busy_q && tx_ready && (idx_q == msg_last_idx(sel_q));

  always_comb begin
    busy_d  = busy_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    nonce_d = nonce_q;
    if (!busy_q) begin
      if (start) begin
        busy_d  = 1'b1;
        idx_d   = 4'd0;
        sel_d   = tx_msg_e'(msg_sel);
        nonce_d = nonce;
      end
    end else if (tx_ready) begin
      if (done) begin
        busy_d = 1'b0;
        idx_d  = 4'd0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  // Byte mux; held at zero between messages.
  always_comb begin
    tx_data = 8'h00;
    if (busy_q) begin
      case (sel_q)
        TXM_ONE: tx_data = MSG_PONG;
        TXM_INFO: begin
          case (idx_q[3:2])
            2'd0:    tx_data = hdr_byte(LEN_INFO, TYPE_GET_INFO, idx_q[1:0]);
            2'd1:    tx_data = word_byte(INFO_ID0, idx_q[1:0]);
            2'd2:    tx_data = word_byte(INFO_ID1, idx_q[1:0]);
            default: tx_data = 8'h00;
          endcase
        end
        TXM_INVALID: begin
          if (idx_q[3:2] == 2'd0) tx_data = hdr_byte(LEN_SHORT, TYPE_INVALID, idx_q[1:0]);
        end
        default: begin
          case (idx_q[3:2])
            2'd0:    tx_data = hdr_byte(LEN_SHORT, TYPE_NONCE, idx_q[1:0]);
            2'd1:    tx_data = word_byte(nonce_q, idx_q[1:0]);
            default: tx_data = 8'h00;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q  <= 1'b0;
      idx_q   <= 4'd0;
      sel_q   <= TXM_ONE;
      nonce_q <= 32'd0;
    end else begin
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      nonce_q <= nonce_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_msg_handler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_msg_handler
//  Description : Host frame parser (PING, GET_INFO, PUSH_JOB), job register
//                file with new_work pulse, one reply slot, one nonce slot and
//                a non-interleaving TX arbiter feeding msg_tx_serializer.
//  Ports       : CLK, RST                 clock, synchronous active-high reset
//                rx_data, rx_valid        received byte stream (no backpressure)
//                tx_data, tx_valid, tx_ready  transmitted byte stream
//                golden_nonce(_valid)     nonce strobe from the hashing core
//                new_work                 1-cycle pulse when job outputs update
//                midstate/data/noncemin/noncemax  job outputs
//                nonce_overflow           pending nonce overwritten
//  Revision    : 1.0  initial release
// ============================================================================
module uart_msg_handler
  import msg_defs::*;
#(
  parameter logic [31:0] INFO_ID0       = 32'hDEADBEEF,
  parameter logic [31:0] INFO_ID1       = 32'h13370D13,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [31:0]  golden_nonce,
  input  logic         golden_nonce_valid,
  output logic         new_work,
  output logic [255:0] midstate,
  output logic [95:0]  data,
  output logic [31:0]  noncemin,
  output logic [31:0]  noncemax,
  output logic         nonce_overflow
);

  localparam int unsigned            IDLE_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0]      IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  // Parser state.
  parse_state_e      state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;        // bytes of the frame received so far
  logic [5:0]        len_q, len_d;
  logic [7:0]        type_q, type_d;
  logic              hdr_bad_q, hdr_bad_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  // Payload bytes 4..55 only (job bits 447:32); the 4 pad bytes are never kept.
  logic [415:0]      job_q, job_d;

  // Job outputs.
  logic [255:0]      midstate_q, midstate_d;
  logic [95:0]       data_q, data_d;
  logic [31:0]       noncemin_q, noncemin_d;
  logic [31:0]       noncemax_q, noncemax_d;
  logic              new_work_q, new_work_d;

  // Slots and arbiter.
  logic              reply_full_q, reply_full_d;
  tx_msg_e           reply_sel_q, reply_sel_d;
  logic              nonce_full_q, nonce_full_d;
  logic [31:0]       nonce_val_q, nonce_val_d;
  logic              nonce_rewr_q, nonce_rewr_d;  // slot refilled while its old value is on the wire
  logic              ovf_q, ovf_d;
  logic              active_nonce_q, active_nonce_d;

  logic              reply_req;
  tx_msg_e           reply_req_sel;
  logic              ser_start;
  tx_msg_e           ser_sel;
  logic              ser_done;
  logic              is_push, is_info;

  assign midstate       = midstate_q;
  assign data           = data_q;
  assign noncemin       = noncemin_q;
  assign noncemax       = noncemax_q;
  assign new_work       = new_work_q;
  assign nonce_overflow = ovf_q;

  assign is_push = (type_q == TYPE_PUSH_JOB) && (len_q == 6'(LEN_PUSH_JOB)) && !hdr_bad_q;
  assign is_info = (type_q == TYPE_GET_INFO) && (len_q == 6'(LEN_GET_INFO)) && !hdr_bad_q;

  // Parser next state and job update.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    type_d        = type_q;
    hdr_bad_d     = hdr_bad_q;
    idle_d        = idle_q;
    job_d         = job_q;
    midstate_d    = midstate_q;
    data_d        = data_q;
    noncemin_d    = noncemin_q;
    noncemax_d    = noncemax_q;
    new_work_d    = 1'b0;
    reply_req     = 1'b0;
    reply_req_sel = TXM_INVALID;

    case (state_q)
      PS_IDLE: begin
        if (rx_valid) begin
          if (rx_data == MSG_PING) begin
            reply_req     = 1'b1;
            reply_req_sel = TXM_ONE;
          end else if (rx_data < MIN_LEN || rx_data > MAX_LEN || rx_data[1:0] != 2'b00) begin
            reply_req     = 1'b1;
            reply_req_sel = TXM_INVALID;
          end else begin
            len_d     = rx_data[5:0];
            cnt_d     = 6'd1;
            hdr_bad_d = 1'b0;
            idle_d    = '0;
            state_d   = PS_HDR;
          end
        end
      end

      default: begin  // PS_HDR, PS_PAYLOAD
        if (rx_valid) begin
          idle_d = '0;
          cnt_d  = cnt_q + 6'd1;
          if (state_q == PS_HDR) begin
            if (cnt_q == 6'd3) begin
              type_d  = rx_data;
              state_d = PS_PAYLOAD;
            end else if (rx_data != 8'h00) begin
              hdr_bad_d = 1'b1;
            end
          end else begin
            if (cnt_q >= 6'd8) job_d[{cnt_q - 6'd8, 3'b000} +: 8] = rx_data;
            if (cnt_q == len_q - 6'd1) begin
              state_d   = PS_IDLE;
              reply_req = 1'b1;
              if (is_push) begin
                noncemax_d    = job_d[31:0];
                noncemin_d    = job_d[63:32];
                data_d        = job_d[159:64];
                midstate_d    = job_d[415:160];
                new_work_d    = 1'b1;
                reply_req_sel = TXM_ONE;
              end else if (is_info) begin
                reply_req_sel = TXM_INFO;
              end else begin
                reply_req_sel = TXM_INVALID;
              end
            end
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = PS_IDLE;  // silent abort
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
    endcase
  end

  // Slots and arbiter. A message ending this cycle frees its slot before any
  // new entry is considered, so a same-cycle entry is neither dropped nor
  // counted as an overflow.
  always_comb begin
    logic reply_done, nonce_done, reply_busy, nonce_busy, nonce_in_flight;
    reply_full_d   = reply_full_q;
    reply_sel_d    = reply_sel_q;
    nonce_full_d   = nonce_full_q;
    nonce_val_d    = nonce_val_q;
    nonce_rewr_d   = nonce_rewr_q;
    ovf_d          = 1'b0;
    active_nonce_d = active_nonce_q;

    reply_done = ser_done && !active_nonce_q;
    nonce_done = ser_done && active_nonce_q;
    reply_busy = reply_full_q && !reply_done;
    nonce_busy = nonce_full_q && (!nonce_done || nonce_rewr_q);

    // Arbiter: only between messages; reply wins.
    ser_start = !tx_valid && (reply_full_q || nonce_full_q);
    ser_sel   = reply_full_q ? reply_sel_q : TXM_NONCE;
    if (ser_start) active_nonce_d = !reply_full_q;

    nonce_in_flight = (tx_valid && active_nonce_q && !nonce_done) ||
                      (ser_start && !reply_full_q);

    reply_full_d = reply_busy;
    if (reply_req && !reply_busy) begin
      reply_full_d = 1'b1;
      reply_sel_d  = reply_req_sel;
    end

    nonce_full_d = nonce_busy;
    if (nonce_done) nonce_rewr_d = 1'b0;
    if (golden_nonce_valid) begin
      nonce_full_d = 1'b1;
      nonce_val_d  = golden_nonce;
      ovf_d        = nonce_busy;
      // The serializer holds its own copy; keep the slot full after that copy ends.
      if (nonce_in_flight) nonce_rewr_d = 1'b1;
    end
  end

  msg_tx_serializer #(
    .INFO_ID0 (INFO_ID0),
    .INFO_ID1 (INFO_ID1)
  ) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .start    (ser_start),
    .msg_sel  (ser_sel),
    .nonce    (nonce_val_q),
    .done     (ser_done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= PS_IDLE;
      cnt_q          <= 6'd0;
      len_q          <= 6'd0;
      type_q         <= 8'd0;
      hdr_bad_q      <= 1'b0;
      idle_q         <= '0;
      job_q          <= '0;
      midstate_q     <= '0;
      data_q         <= '0;
      noncemin_q     <= '0;
      noncemax_q     <= '0;
      new_work_q     <= 1'b0;
      reply_full_q   <= 1'b0;
      reply_sel_q    <= TXM_ONE;
      nonce_full_q   <= 1'b0;
      nonce_val_q    <= '0;
      nonce_rewr_q   <= 1'b0;
      ovf_q          <= 1'b0;
      active_nonce_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      type_q         <= type_d;
      hdr_bad_q      <= hdr_bad_d;
      idle_q         <= idle_d;
      job_q          <= job_d;
      midstate_q     <= midstate_d;
      data_q         <= data_d;
      noncemin_q     <= noncemin_d;
      noncemax_q     <= noncemax_d;
      new_work_q     <= new_work_d;
      reply_full_q   <= reply_full_d;
      reply_sel_q    <= reply_sel_d;
      nonce_full_q   <= nonce_full_d;
      nonce_val_q    <= nonce_val_d;
      nonce_rewr_q   <= nonce_rewr_d;
      ovf_q          <= ovf_d;
      active_nonce_q <= active_nonce_d;
    end
  end

endmodule
`default_nettype wire
